freq_change_seq: RTL and testbench
==================================

Name: freq_change_seq

Overview:
- Parametrised multi-channel frequency-change sequencer for the APB slave register block.
- Register block supplies a start pulse, target frequency-set-point index and channel mask.
- Block runs the handshake per channel: start → ready → host PLL reprogram → PLL-done → done.
- Adds per-channel masking, per-channel error capture, a current-index register and a watchdog timeout.

Parameters:
- NB_CH, 2, number of memory channels/ranks sequenced in parallel.
- NB_FSP, 8, number of legal frequency set points; FIDX_W = $clog2(NB_FSP), minimum 1.
- TOUT_W, 16, width of the watchdog counter and limit.

Ports:
- pclk_i  in  1  clock, all logic on rising edge.
- prst_ni  in  1  reset, synchronous, active-low.
- req_i  in  1  one-cycle start pulse (register start_freq_change bit).
- freq_idx_i  in  FIDX_W  target set point, sampled with req_i.
- ch_mask_i  in  NB_CH  participating channels, sampled with req_i.
- pll_done_i  in  1  one-cycle pulse: host finished PLL reprogram (register pll bit).
- tout_limit_i  in  TOUT_W  watchdog limit in cycles; 0 disables.
- freq_change_ready_i  in  NB_CH  per-channel ready pulse/level.
- freq_change_done_i  in  NB_CH  per-channel done pulse/level.
- freq_change_error_i  in  NB_CH  per-channel error.
- start_freq_change_o  out  NB_CH  per-channel start request.
- pll_freq_chng_done_o  out  NB_CH  per-channel PLL-relocked indication.
- pll_req_o  out  1  level; host must reprogram PLL (drives interrupt status).
- cur_freq_idx_o  out  FIDX_W  last successfully applied index.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse on any failure.
- err_status_o  out  NB_CH  sticky per-channel error flags.
- tout_o  out  1  sticky: last failure was a timeout.

Behaviour:
- Reset (prst_ni=0 at edge): state IDLE; all outputs 0; cur_freq_idx_o=0; internal seen-vectors and counter 0. Reset mid-sequence aborts immediately with no done_o/err_o pulse.
- States: IDLE, WAIT_RDY, PLL, WAIT_DONE, ERR. All outputs registered.
- IDLE, req_i=1:
  - ch_mask_i==0 or freq_idx_i>=NB_FSP: err_o pulses next cycle; stay IDLE; err_status_o unchanged.
  - Otherwise: latch idx/mask; clear err_status_o, tout_o, seen-vectors, counter; → WAIT_RDY. start_freq_change_o=mask at N+1.
- WAIT_RDY:
  - Sample ready&mask into rdy_seen; each channel's start bit drops the cycle after its ready is seen.
  - rdy_seen==mask → PLL; pll_req_o=1 next cycle.
- PLL: wait for pll_done_i; no timeout here. On pll_done_i → WAIT_DONE; pll_req_o=0 and pll_freq_chng_done_o=mask next cycle.
- WAIT_DONE:
  - Sample done&mask; each channel's pll_freq_chng_done_o bit drops after its done is seen.
  - All seen → IDLE; cur_freq_idx_o=target; done_o pulse; busy_o=0, all in the same cycle.
- Ignored inputs:
  - Ready/done/error on unmasked channels.
  - done in WAIT_RDY; ready in WAIT_DONE.
  - pll_done_i outside PLL.
  - req_i outside IDLE (dropped, no side effect).
- Error: any (error&mask) in WAIT_RDY/PLL/WAIT_DONE → ERR.
  - OR error bits into err_status_o.
  - Clear start_freq_change_o, pll_freq_chng_done_o, pll_req_o.
  - err_o pulse; next cycle → IDLE. cur_freq_idx_o unchanged.
- Priority in one cycle: error > timeout > completion. Error coinciding with the final ready/done → ERR.
- Watchdog: counter cleared on entry to WAIT_RDY and WAIT_DONE; increments each cycle in those states.
  - tout_limit_i!=0 and count==tout_limit_i-1 with completion not met → ERR with tout_o=1. tout_limit_i=L allows exactly L cycles.
  - Counter saturates, no wrap.

Optional Feature:
- Macro FREQ_SEQ_WATCHDOG_EN.
- Defined: watchdog as above.
- Undefined: counter not built; tout_limit_i ignored; tout_o tied 0; WAIT_RDY/WAIT_DONE wait indefinitely.

Test Plan:
- Mask=2'b11, idx=5, ready both @+3, pll_done_i @+10, done both @+4 → start 2'b11 @N+1; pll_req_o high until pll_done_i+1; done_o once; cur_freq_idx_o=5.
- Mask=2'b01, ch1 toggles ready/done/error → ch1 ignored, completes normally, start_freq_change_o[1] never high.
- Mask=2'b11, ch0 ready @+2, ch1 error @+4 → err_o pulse, err_status_o=2'b10, outputs cleared, cur_freq_idx_o unchanged, IDLE next cycle.
- FREQ_SEQ_WATCHDOG_EN defined, tout_limit_i=8, ch1 never ready → ERR after 8 WAIT_RDY cycles, tout_o=1. Undefined → busy_o stays 1.
- Invalid requests: idx=NB_FSP → err_o only, state IDLE. mask=0 → same. req_i during PLL → no effect, sequence completes.
- prst_ni=0 during WAIT_DONE → all outputs 0, cur_freq_idx_o=0 next edge; new req accepted after release.

Source files
------------

// File: rtl/freq_change_seq.sv
// Multi-channel frequency-change sequencer: start -> ready -> PLL reprogram -> PLL done -> done.
// Optional watchdog on the ready/done waits is built when FREQ_SEQ_WATCHDOG_EN is defined.
module freq_change_seq #(
  parameter  int unsigned NB_CH  = 2,
  parameter  int unsigned NB_FSP = 8,
  parameter  int unsigned TOUT_W = 16,
  localparam int unsigned FIDX_W = (NB_FSP > 1) ? $clog2(NB_FSP) : 1
) (
  input  logic              pclk_i,
  input  logic              prst_ni,
  input  logic              req_i,
  input  logic [FIDX_W-1:0] freq_idx_i,
  input  logic [NB_CH-1:0]  ch_mask_i,
  input  logic              pll_done_i,
  input  logic [TOUT_W-1:0] tout_limit_i,
  input  logic [NB_CH-1:0]  freq_change_ready_i,
  input  logic [NB_CH-1:0]  freq_change_done_i,
  input  logic [NB_CH-1:0]  freq_change_error_i,
  output logic [NB_CH-1:0]  start_freq_change_o,
  output logic [NB_CH-1:0]  pll_freq_chng_done_o,
  output logic              pll_req_o,
  output logic [FIDX_W-1:0] cur_freq_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [NB_CH-1:0]  err_status_o,
  output logic              tout_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_PLL, S_WAIT_DONE, S_ERR} state_e;

  state_e            state_q;
  logic [NB_CH-1:0]  mask_q, seen_q, seen_d, start_q, plldn_q, err_status_q;
  logic [FIDX_W-1:0] tgt_q, cur_q;
  logic              pll_req_q, busy_q, done_q, err_q, tout_q;
  logic [NB_CH-1:0]  err_hit;
  logic              req_bad, cmpl, waiting, active, err_fire, tout_hit, tout_fire;

  assign err_hit  = freq_change_error_i & mask_q;
  assign req_bad  = (ch_mask_i == '0) || (32'(freq_idx_i) >= NB_FSP);
  assign waiting  = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_DONE);
  assign active   = waiting || (state_q == S_PLL);
  assign cmpl     = (seen_d == mask_q);
  assign err_fire = active && (|err_hit);
  assign tout_fire = waiting && tout_hit && !cmpl;

  always_comb begin
    seen_d = seen_q;
    if (state_q == S_WAIT_RDY)
      seen_d = seen_q | (freq_change_ready_i & mask_q);
    else if (state_q == S_WAIT_DONE)
      seen_d = seen_q | (freq_change_done_i & mask_q);
  end

`ifdef FREQ_SEQ_WATCHDOG_EN
  logic [TOUT_W-1:0] cnt_q;

  assign tout_hit = (tout_limit_i != '0) && (cnt_q == tout_limit_i - TOUT_W'(1));

  // Held at zero outside the wait states so each wait starts counting from 0.
  always_ff @(posedge pclk_i) begin
    if (!prst_ni)
      cnt_q <= '0;
    else if (!waiting)
      cnt_q <= '0;
    else if (cnt_q != '1)
      cnt_q <= cnt_q + TOUT_W'(1);
  end
`else
  logic unused_tout_limit;
  assign unused_tout_limit = ^tout_limit_i;
  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge pclk_i) begin
    if (!prst_ni) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      seen_q       <= '0;
      start_q      <= '0;
      plldn_q      <= '0;
      err_status_q <= '0;
      tgt_q        <= '0;
      cur_q        <= '0;
      pll_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Error outranks timeout, which outranks completion in the same cycle.
      if (err_fire || tout_fire) begin
        state_q      <= S_ERR;
        err_status_q <= err_status_q | err_hit;
        tout_q       <= !err_fire;
        start_q      <= '0;
        plldn_q      <= '0;
        pll_req_q    <= 1'b0;
        err_q        <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req_i) begin
              if (req_bad) begin
                err_q <= 1'b1;
              end else begin
                tgt_q        <= freq_idx_i;
                mask_q       <= ch_mask_i;
                seen_q       <= '0;
                err_status_q <= '0;
                tout_q       <= 1'b0;
                start_q      <= ch_mask_i;
                busy_q       <= 1'b1;
                state_q      <= S_WAIT_RDY;
              end
            end
          end
          S_WAIT_RDY: begin
            seen_q  <= seen_d;
            start_q <= mask_q & ~seen_d;
            if (cmpl) begin
              seen_q    <= '0;
              pll_req_q <= 1'b1;
              state_q   <= S_PLL;
            end
          end
          S_PLL: begin
            if (pll_done_i) begin
              pll_req_q <= 1'b0;
              plldn_q   <= mask_q;
              state_q   <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            seen_q  <= seen_d;
            plldn_q <= mask_q & ~seen_d;
            if (cmpl) begin
              seen_q  <= '0;
              cur_q   <= tgt_q;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          S_ERR: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign start_freq_change_o  = start_q;
  assign pll_freq_chng_done_o = plldn_q;
  assign pll_req_o            = pll_req_q;
  assign cur_freq_idx_o       = cur_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign err_status_o         = err_status_q;
  assign tout_o               = tout_q;

endmodule

// File: tb/tb_freq_change_seq.sv
// Scoreboard bench for freq_change_seq: outcomes are predicted from per-sequence event
// schedules (edge numbers of ready/PLL/done/error) and checked by an independent monitor.
module tb_freq_change_seq;

  localparam int unsigned NB_CH  = 2;
  localparam int unsigned NB_FSP = 6;
  localparam int unsigned TOUT_W = 16;
  localparam int unsigned FIDX_W = 3;

  logic              pclk = 1'b0;
  logic              prst_ni;
  logic              req_i;
  logic [FIDX_W-1:0] freq_idx_i;
  logic [NB_CH-1:0]  ch_mask_i;
  logic              pll_done_i;
  logic [TOUT_W-1:0] tout_limit_i;
  logic [NB_CH-1:0]  rdy_i, dn_i, er_i;
  logic [NB_CH-1:0]  start_o, plldn_o, err_status_o;
  logic              pll_req_o, busy_o, done_o, err_o, tout_o;
  logic [FIDX_W-1:0] cur_o;

  freq_change_seq #(.NB_CH(NB_CH), .NB_FSP(NB_FSP), .TOUT_W(TOUT_W)) dut (
    .pclk_i(pclk), .prst_ni(prst_ni), .req_i(req_i), .freq_idx_i(freq_idx_i),
    .ch_mask_i(ch_mask_i), .pll_done_i(pll_done_i), .tout_limit_i(tout_limit_i),
    .freq_change_ready_i(rdy_i), .freq_change_done_i(dn_i), .freq_change_error_i(er_i),
    .start_freq_change_o(start_o), .pll_freq_chng_done_o(plldn_o), .pll_req_o(pll_req_o),
    .cur_freq_idx_o(cur_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_status_o(err_status_o), .tout_o(tout_o)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic              is_err;
    logic [FIDX_W-1:0] idx;
    logic [NB_CH-1:0]  st;
    logic              tout;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference-model architectural state
  logic [FIDX_W-1:0] m_cur = '0;
  logic [NB_CH-1:0]  m_st  = '0;
  logic              m_tout = 1'b0;

  // Per-channel schedule: edge numbers (relative to the request edge) of each event; 0 = none
  int sr[NB_CH], sd[NB_CH], se[NB_CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 1'b0; pll_done_i = 1'b0; rdy_i = '0; dn_i = '0; er_i = '0;
  endtask

  always @(negedge pclk) begin
    if (prst_ni && (done_o || err_o)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done_o, err_o}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("outcome", {24'd0, done_o, err_o, cur_o, err_status_o, tout_o},
            {24'd0, ~e.is_err, e});
      end
    end
  end

  task automatic bad_req(input logic [NB_CH-1:0] mask, input logic [FIDX_W-1:0] idx);
    exp_t e;
    e = '{is_err: 1'b1, idx: m_cur, st: m_st, tout: m_tout};
    q.push_back(e);
    req_i = 1'b1; freq_idx_i = idx; ch_mask_i = mask;
    tick();
    req_i = 1'b0;
    tick();
    chk("bad_req_idle", {31'd0, busy_o}, 32'd0);
  endtask

  // p = PLL-done edge; done edge of channel c is p + sd[c]; extra = req_i pulse while in PLL
  task automatic run_seq(input logic [NB_CH-1:0] mask, input logic [FIDX_W-1:0] idx,
                         input logic [TOUT_W-1:0] lim, input int p, input bit extra,
                         input int rst_at);
    int  rmax = 0, dmax = 0, d, emin = 0, tedge = 0, x;
    bit  is_err = 1'b0, is_to = 1'b0, stray = 1'b0;
    logic [NB_CH-1:0] st = '0;
    exp_t e;
    for (int c = 0; c < NB_CH; c++)
      if (mask[c]) begin
        if (sr[c] > rmax) rmax = sr[c];
        if (sd[c] > dmax) dmax = sd[c];
      end
    d = p + dmax;
    for (int c = 0; c < NB_CH; c++)
      if (mask[c] && se[c] >= 1 && se[c] <= d && (emin == 0 || se[c] < emin)) emin = se[c];
`ifdef FREQ_SEQ_WATCHDOG_EN
    if (lim != 0) begin
      if (rmax > int'(lim)) tedge = int'(lim);
      else if (dmax > int'(lim)) tedge = p + int'(lim);
    end
`endif
    if (emin != 0 && (tedge == 0 || emin <= tedge)) begin
      x = emin; is_err = 1'b1;
      for (int c = 0; c < NB_CH; c++) if (mask[c] && se[c] == emin) st[c] = 1'b1;
    end else if (tedge != 0) begin
      x = tedge; is_err = 1'b1; is_to = 1'b1;
    end else begin
      x = d;
    end
    if (rst_at == 0) begin
      m_st = st; m_tout = is_to;
      if (!is_err) m_cur = idx;
      e = '{is_err: is_err, idx: m_cur, st: m_st, tout: m_tout};
      q.push_back(e);
    end

    req_i = 1'b1; freq_idx_i = idx; ch_mask_i = mask; tout_limit_i = lim;
    tick();
    req_i = 1'b0;
    chk("start_at_n1", {30'd0, start_o}, {30'd0, mask});
    for (int k = 1; k <= x; k++) begin
      for (int c = 0; c < NB_CH; c++) begin
        rdy_i[c] = mask[c] ? (k == sr[c])      : 1'($urandom_range(0, 1));
        dn_i[c]  = mask[c] ? (k == p + sd[c])  : 1'($urandom_range(0, 1));
        er_i[c]  = mask[c] ? (k == se[c])      : 1'($urandom_range(0, 1));
      end
      pll_done_i = (k == p);
      req_i = extra && (k == p);
      freq_idx_i = FIDX_W'($urandom_range(0, 7));
      if (k == rst_at) prst_ni = 1'b0;
      tick();
      if (k == rst_at) begin
        chk("reset_outputs", {18'd0, start_o, plldn_o, pll_req_o, cur_o, busy_o, done_o,
                              err_o, err_status_o, tout_o}, 32'd0);
        prst_ni = 1'b1;
        idle_inputs();
        m_cur = '0; m_st = '0; m_tout = 1'b0;
        return;
      end
      if ((start_o & ~mask) != '0 || (plldn_o & ~mask) != '0) stray = 1'b1;
      if (busy_o != ((k < x) || is_err)) stray = 1'b1;
      if (k == rmax && x > rmax) chk("pll_req_set", {31'd0, pll_req_o}, 32'd1);
      if (k == p && x > p) chk("pll_relock", {29'd0, pll_req_o, plldn_o}, {29'd0, 1'b0, mask});
    end
    idle_inputs();
    tick();
    chk("idle_after", {31'd0, busy_o}, 32'd0);
    chk("no_stray", {31'd0, stray}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    prst_ni = 1'b0; freq_idx_i = '0; ch_mask_i = '0; tout_limit_i = '0;
    idle_inputs();
    repeat (3) tick();
    chk("reset_state", {18'd0, start_o, plldn_o, pll_req_o, cur_o, busy_o, done_o, err_o,
                        err_status_o, tout_o}, 32'd0);
    prst_ni = 1'b1;
    tick();

    // Both channels, idx 5, with a req_i pulse while waiting for the PLL
    sr = '{3, 3}; sd = '{4, 4}; se = '{0, 0};
    run_seq(2'b11, 3'd5, '0, 13, 1'b1, 0);

    // Channel 1 unmasked and toggling noise
    sr = '{2, 9}; sd = '{3, 9}; se = '{0, 2};
    run_seq(2'b01, 3'd2, '0, 5, 1'b0, 0);

    // Channel 1 error mid-wait
    sr = '{2, 50}; sd = '{1, 1}; se = '{0, 4};
    run_seq(2'b11, 3'd4, '0, 60, 1'b0, 0);

    // Channel 1 ready very late against a limit of 8
    sr = '{2, 30}; sd = '{2, 2}; se = '{0, 0};
    run_seq(2'b11, 3'd1, 16'd8, 35, 1'b0, 0);

    // Error on the same edge as the final ready
    sr = '{2, 3}; sd = '{2, 2}; se = '{3, 0};
    run_seq(2'b11, 3'd3, '0, 6, 1'b0, 0);

    bad_req(2'b11, 3'd6);
    bad_req(2'b00, 3'd2);

    // Reset while waiting for done, then a fresh sequence
    sr = '{1, 2}; sd = '{5, 5}; se = '{0, 0};
    run_seq(2'b11, 3'd3, '0, 4, 1'b0, 6);
    tick();
    sr = '{1, 1}; sd = '{1, 2}; se = '{0, 0};
    run_seq(2'b10, 3'd0, '0, 3, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [NB_CH-1:0]  mask;
      logic [TOUT_W-1:0] lim;
      for (int c = 0; c < NB_CH; c++) begin
        sr[c] = $urandom_range(1, 6);
        sd[c] = $urandom_range(1, 6);
        se[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      end
      mask = NB_CH'($urandom_range(1, 3));
      lim  = ($urandom_range(0, 1) == 0) ? '0 : TOUT_W'($urandom_range(1, 8));
      if ($urandom_range(0, 7) == 0) bad_req(mask, 3'd7);
      run_seq(mask, FIDX_W'($urandom_range(0, NB_FSP - 1)), lim,
              7 + int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
